// File: rtl/if_rd_pkg.sv
// Shared definitions for the SPI read-link scheduler: interface codes per
// requester slot and the scheduler FSM states.
package if_rd_pkg;

  localparam int IF_NUM_REQ = 5;

  localparam logic [3:0] IFCODE_NONE   = 4'h0;
  localparam logic [3:0] IFCODE_CFG    = 4'h1;
  localparam logic [3:0] IFCODE_ACT    = 4'h2;
  localparam logic [3:0] IFCODE_FLGACT = 4'h3;
  localparam logic [3:0] IFCODE_WEI    = 4'h4;
  localparam logic [3:0] IFCODE_FLGWEI = 4'h5;

  // Requester index -> interface code sent on config_data.
  localparam logic [3:0] IFCODE_TBL [IF_NUM_REQ] = '{
    IFCODE_CFG, IFCODE_ACT, IFCODE_FLGACT, IFCODE_WEI, IFCODE_FLGWEI
  };

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    XFER,
    RELEASE
  } rd_state_e;

  // Table lookup that tolerates indices beyond the table (yields IFCODE_NONE).
  function automatic logic [3:0] ifcode_of(input int idx);
    logic [3:0] code;
    code = IFCODE_NONE;
    for (int i = 0; i < IF_NUM_REQ; i++) begin
      if (idx == i) code = IFCODE_TBL[i];
    end
    return code;
  endfunction

endpackage

// File: rtl/if_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr_i, wrapping cyclically, as both a one-hot vector and an index.
module rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin : pick
    int cand;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    cand    = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = IDX_W'(cand);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_rd_arbiter.sv
// Round-robin scheduler of the shared off-chip SPI read link. One requester
// at a time owns the link from ISSUE until the link reports done and is idle.
module if_rd_arbiter
  import if_rd_pkg::*;
#(
  parameter int NUM_REQ     = 5,
  parameter int SPI_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic                   clk_chip,
  input  logic                   reset_n_chip,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_rst,
  input  logic [NUM_REQ-1:0]     dst_rdy,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     dst_valid,
  output logic [SPI_WIDTH-1:0]   dst_data,
  output logic [NUM_REQ-1:0]     done,
  input  logic                   config_ready,
  output logic                   config_paulse,
  output logic [3:0]             config_data,
  output logic [2:0]             Reset_IF_CFG,
  output logic                   rd_req,
  input  logic                   rd_valid,
  input  logic [SPI_WIDTH-1:0]   rd_data,
  input  logic                   rd_done,
  output logic                   err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  rd_state_e          state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         code_q, code_d;
  logic [2:0]         rst_cfg_q, rst_cfg_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // State and scheduling registers; async reset puts the link back to IDLE at once.
  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      code_q    <= '0;
      rst_cfg_q <= '0;
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      rst_cfg_q <= rst_cfg_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic plus the per-state link and requester strobes.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    win_d         = win_q;
    ptr_d         = ptr_q;
    code_d        = code_q;
    rst_cfg_d     = rst_cfg_q;
    to_cnt_d      = to_cnt_q;
    err_d         = err_q;
    config_paulse = 1'b0;
    rd_req        = 1'b0;
    dst_valid     = '0;
    done          = '0;

    unique case (state_q)
      IDLE: begin
        if (|req && config_ready) state_d = ARB;
      end
      ARB: begin
        // Requests may have been withdrawn since IDLE; fall back if none remain.
        if (pick_valid) begin
          gnt_d     = pick_gnt;
          win_d     = pick_idx;
          code_d    = ifcode_of(int'(pick_idx));
          rst_cfg_d = req_rst[3*int'(pick_idx) +: 3];
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        config_paulse = 1'b1;
        to_cnt_d      = '0;
        state_d       = XFER;
      end
      XFER: begin
        rd_req           = dst_rdy[win_q];
        dst_valid[win_q] = rd_valid;
        // Count silent cycles; saturate so the flag cannot be lost to a wrap.
        if (rd_valid) begin
          to_cnt_d = '0;
        end else if (to_cnt_q != TO_LIMIT) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (to_cnt_d == TO_LIMIT) err_d = 1'b1;
        if (rd_done) begin
          done[win_q] = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        // Hold the grant until the link reports idle, then advance past the winner.
        if (config_ready) begin
          gnt_d   = '0;
          ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt          = gnt_q;
  assign dst_data     = rd_data;
  assign config_data  = code_q;
  assign Reset_IF_CFG = rst_cfg_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_if_rd_arbiter.sv
// Randomized self-checking bench for if_rd_arbiter against a transaction-level
// model: winner = first pending request at or after the model pointer.
module tb_if_rd_arbiter;
  import if_rd_pkg::*;

  localparam int N   = 5;
  localparam int W   = 32;
  localparam int TO  = 16;
  localparam int TOW = 5;
  localparam int RW  = 3 * N;

  localparam logic [3:0] EXP_CODE [N] = '{
    IFCODE_CFG, IFCODE_ACT, IFCODE_FLGACT, IFCODE_WEI, IFCODE_FLGWEI
  };

  logic          clk_chip = 1'b0;
  logic          reset_n_chip;
  logic [N-1:0]  req;
  logic [RW-1:0] req_rst;
  logic [N-1:0]  dst_rdy;
  logic [N-1:0]  gnt;
  logic [N-1:0]  dst_valid;
  logic [W-1:0]  dst_data;
  logic [N-1:0]  done;
  logic          config_ready;
  logic          config_paulse;
  logic [3:0]    config_data;
  logic [2:0]    Reset_IF_CFG;
  logic          rd_req;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_done;
  logic          err_timeout;

  int   checks = 0;
  int   errors = 0;
  int   exp_ptr = 0;
  logic model_err = 1'b0;

  if_rd_arbiter #(
    .NUM_REQ     (N),
    .SPI_WIDTH   (W),
    .TIMEOUT_CYC (TO),
    .TO_W        (TOW)
  ) dut (
    .clk_chip      (clk_chip),
    .reset_n_chip  (reset_n_chip),
    .req           (req),
    .req_rst       (req_rst),
    .dst_rdy       (dst_rdy),
    .gnt           (gnt),
    .dst_valid     (dst_valid),
    .dst_data      (dst_data),
    .done          (done),
    .config_ready  (config_ready),
    .config_paulse (config_paulse),
    .config_data   (config_data),
    .Reset_IF_CFG  (Reset_IF_CFG),
    .rd_req        (rd_req),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_done       (rd_done),
    .err_timeout   (err_timeout)
  );

  always #5 clk_chip = ~clk_chip;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check_reset_outputs();
    check("rst_gnt", gnt, '0);
    check("rst_dst_valid", dst_valid, '0);
    check("rst_done", done, '0);
    check("rst_paulse", config_paulse, 0);
    check("rst_config_data", config_data, '0);
    check("rst_reset_if_cfg", Reset_IF_CFG, '0);
    check("rst_rd_req", rd_req, 0);
    check("rst_err", err_timeout, 0);
    check("rst_dst_data", dst_data, rd_data);
  endtask

  // Asserts reset away from a clock edge with all link inputs active, then
  // releases it on a falling edge with the given request pattern applied.
  task automatic apply_reset(input logic [N-1:0] r, input logic [RW-1:0] rr);
    @(negedge clk_chip);
    #2;
    dst_rdy = '1; rd_valid = 1'b1; rd_done = 1'b1; rd_data = $urandom;
    reset_n_chip = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk_chip);
    req = r; req_rst = rr;
    dst_rdy = '0; rd_valid = 1'b0; rd_done = 1'b0; config_ready = 1'b1;
    reset_n_chip = 1'b1;
    exp_ptr = 0;
    model_err = 1'b0;
  endtask

  // Counts falling edges until config_paulse, with random link noise that must be ignored.
  task automatic wait_issue(output int lat);
    lat = 0;
    while (config_paulse !== 1'b1 && lat < 20) begin
      @(negedge clk_chip);
      rd_valid = 1'($urandom_range(0, 1));
      rd_done  = 1'($urandom_range(0, 1));
      rd_data  = $urandom;
      #1;
      lat++;
      check("pre_xfer_dst_valid", dst_valid, '0);
      check("pre_xfer_done", done, '0);
      check("pre_xfer_rd_req", rd_req, 0);
    end
    if (config_paulse !== 1'b1) check("issue_seen", config_paulse, 1);
  endtask

  // One complete transaction, starting on a falling edge with the DUT idle.
  task automatic run_txn(input int ncyc, input bit last_valid, input bit to_mode,
                         input bit rand_req, input bit drop_req);
    int           w, lat, nwait;
    logic [2:0]   exp_rst;
    logic [3:0]   exp_code;
    logic [N-1:0] wbit;
    w = model_pick(req, exp_ptr);
    if (w < 0) w = 0;
    exp_rst  = req_rst[3*w +: 3];
    exp_code = EXP_CODE[w];
    wbit     = bit_of(w);

    wait_issue(lat);
    check("issue_latency", lat, 2);
    check("issue_gnt", gnt, wbit);
    check("issue_config_data", config_data, exp_code);
    check("issue_reset_if_cfg", Reset_IF_CFG, exp_rst);

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_chip);
      dst_rdy = N'($urandom);
      rd_data = $urandom;
      req_rst = RW'($urandom);
      if (to_mode) rd_valid = (c == 9);
      else if (c == ncyc - 1) rd_valid = last_valid;
      else rd_valid = 1'($urandom_range(0, 1));
      rd_done = (c == ncyc - 1);
      if (c == 0 && rand_req) req = req | (N'($urandom) & ~wbit);
      if (c == 0 && drop_req) req = req & ~wbit;
      if (to_mode) model_err = (c >= 26);
      #1;
      check("xfer_rd_req", rd_req, dst_rdy[w]);
      check("xfer_dst_valid", dst_valid, rd_valid ? wbit : '0);
      check("xfer_done", done, rd_done ? wbit : '0);
      check("xfer_dst_data", dst_data, rd_data);
      check("xfer_gnt", gnt, wbit);
      check("xfer_paulse", config_paulse, 0);
      check("xfer_config_data", config_data, exp_code);
      check("xfer_reset_if_cfg", Reset_IF_CFG, exp_rst);
      if (!to_mode || c != 25) check("xfer_err_timeout", err_timeout, model_err);
    end

    nwait = $urandom_range(0, 3);
    for (int i = 0; i <= nwait; i++) begin
      @(negedge clk_chip);
      rd_done = 1'b0; rd_valid = 1'b1; dst_rdy = '1;
      config_ready = (i == nwait);
      #1;
      check("rel_dst_valid", dst_valid, '0);
      check("rel_done", done, '0);
      check("rel_rd_req", rd_req, 0);
      check("rel_gnt", gnt, wbit);
      check("rel_paulse", config_paulse, 0);
    end

    @(negedge clk_chip);
    rd_valid = 1'b0;
    exp_ptr = (w + 1) % N;
    if (rand_req) begin
      req = req & ~wbit;
      if ($urandom_range(0, 2) == 0) req = req | wbit;
      req = req | (N'($urandom) & N'($urandom));
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      req_rst = RW'($urandom);
    end
    #1;
    check("idle_gnt", gnt, '0);
    check("idle_err_timeout", err_timeout, model_err);
  endtask

  initial begin
    logic [RW-1:0] rr1;
    int            w, lat;
    logic [N-1:0]  wbit;

    reset_n_chip = 1'b1;
    req = '0; req_rst = '0; dst_rdy = '0;
    config_ready = 1'b1; rd_valid = 1'b0; rd_data = '0; rd_done = 1'b0;

    // Single WEI request with Reset_IF_CFG 101; longer transfer with rdy toggling,
    // ending in rd_valid together with rd_done.
    rr1 = '0;
    rr1[11:9] = 3'b101;
    apply_reset(5'b01000, rr1);
    run_txn(14, 1'b1, 1'b0, 1'b0, 1'b0);

    // All requesters pending from reset: service order 0,1,2,3,4,0.
    apply_reset('1, RW'($urandom));
    for (int t = 0; t < 6; t++) run_txn($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

    // Random traffic: new requests during transfers, re-requests after done, dropped reqs.
    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
              ($urandom_range(0, 3) == 0));
    end

    // Silent transfer: one word at cycle 10, then quiet until the timeout flag sets.
    run_txn(30, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a transfer, then arbitration restarts from pointer 0.
    w    = model_pick(req, exp_ptr);
    if (w < 0) w = 0;
    wbit = bit_of(w);
    wait_issue(lat);
    check("pre_reset_issue_gnt", gnt, wbit);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_chip);
      dst_rdy = '1; rd_valid = 1'b1; rd_done = 1'b0; rd_data = $urandom;
      #1;
      check("pre_reset_dst_valid", dst_valid, wbit);
    end
    #2;
    rd_done = 1'b1;
    reset_n_chip = 1'b0;
    #1;
    check_reset_outputs();
    model_err = 1'b0;
    @(negedge clk_chip);
    rd_done = 1'b0; rd_valid = 1'b0; dst_rdy = '0;
    req = '1; req_rst = RW'($urandom);
    reset_n_chip = 1'b1;
    exp_ptr = 0;
    run_txn(5, 1'b1, 1'b0, 1'b1, 1'b0);
    run_txn(3, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
